fetch_module: RTL

//  IF stage of the 5-stage MIPS core; producer end of the IF/ID interface that Decode_module consumes.

---
 rtl/fetch_module_pkg.sv | 13 +
 rtl/fetch_module_instr_mem.sv | 17 +
 rtl/fetch_module.sv | 89 ++++++++
 3 files changed

// File: rtl/fetch_module_pkg.sv
// fetch_module_pkg: shared widths, opcodes and FSM encoding for the IF stage.
package fetch_module_pkg;
  localparam int DEF_NB_BITS = 32;
  localparam int DEF_NB_JUMP = 28;
  localparam int DEF_NB_ADDR = 10;
  localparam logic [5:0] OP_INSTR_HALT = 6'b111111;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  typedef enum logic [1:0] {
    IF_IDLE   = 2'd0,
    IF_RUN    = 2'd1,
    IF_HALTED = 2'd2
  } if_state_e;
endpackage

// File: rtl/fetch_module_instr_mem.sv
// instr_mem: program memory with synchronous write and asynchronous read.
module instr_mem #(
  parameter int NB_BITS = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clk,
  input  logic               i_wenb,
  input  logic [NB_ADDR-1:0] i_waddr,
  input  logic [NB_BITS-1:0] i_wdata,
  input  logic [NB_ADDR-1:0] i_raddr,
  output logic [NB_BITS-1:0] o_rdata
);
  logic [NB_BITS-1:0] mem_q [2**NB_ADDR];
  always_ff @(posedge i_clk)
    if (i_wenb) mem_q[i_waddr] <= i_wdata;
  assign o_rdata = mem_q[i_raddr];
endmodule

// File: rtl/fetch_module.sv
// fetch_module: IF stage holding PC, program memory and the IF/ID latch.
module fetch_module
  import fetch_module_pkg::*;
#(
  parameter int NB_BITS = DEF_NB_BITS,
  parameter int NB_JMP  = DEF_NB_JUMP,
  parameter int NB_ADDR = DEF_NB_ADDR
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_enable,
  input  logic               i_stall,
  input  logic               i_pc_src,
  input  logic               i_pc_beq,
  input  logic [NB_JMP-1:0]  i_jmp_addr,
  input  logic [NB_BITS-1:0] i_brh_addr,
  input  logic               i_flush,
  input  logic               i_mem_wenb,
  input  logic [NB_ADDR-1:0] i_mem_addr,
  input  logic [NB_BITS-1:0] i_mem_data,
  output logic [NB_BITS-1:0] o_if_id_pc,
  output logic [NB_BITS-1:0] o_if_id_instr,
  output logic [NB_BITS-1:0] o_pc,
  output logic               o_halt,
  output logic [1:0]         o_state
);
  localparam logic [NB_BITS-1:0] NOP = NB_BITS'(NOP_INSTR);
  if_state_e state_q, state_d;
  logic [NB_BITS-1:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d, pc_plus4, fetched;
  logic halt_q, halt_d, run, adv, restart, squash, fetch_halt;

  instr_mem #(.NB_BITS(NB_BITS), .NB_ADDR(NB_ADDR)) u_mem (
    .i_clk  (i_clk),
    .i_wenb (i_mem_wenb & ~run),
    .i_waddr(i_mem_addr),
    .i_wdata(i_mem_data),
    .i_raddr(pc_q[NB_ADDR+1:2]),
    .o_rdata(fetched)
  );

  assign run        = state_q == IF_RUN;
  assign restart    = i_start & ~run;
  assign adv        = run & i_enable & ~i_stall;
  assign squash     = i_pc_src | i_pc_beq | i_flush;
  assign pc_plus4   = pc_q + NB_BITS'(4);
  assign fetch_halt = adv & ~squash & (fetched[NB_BITS-1 -: 6] == OP_INSTR_HALT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IF_IDLE;
      pc_q       <= '0;
      if_pc_q    <= '0;
      if_instr_q <= NOP;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      halt_q     <= halt_d;
    end
  end

  always_comb
    state_d = restart ? IF_RUN : fetch_halt ? IF_HALTED : state_q;

  // Jump outranks branch; the sequentially fetched word is dropped on any redirect.
  always_comb begin
    pc_d       = restart ? '0 : pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = run ? if_instr_q : NOP;
    halt_d     = ~restart & (halt_q | fetch_halt);
    if (adv) begin
      pc_d       = i_pc_src ? {pc_plus4[NB_BITS-1:NB_JMP], i_jmp_addr} : i_pc_beq ? i_brh_addr : pc_plus4;
      pc_d[1:0]  = 2'b00;
      if_pc_d    = pc_plus4;
      if_instr_d = squash ? NOP : fetched;
    end
  end

  always_comb begin
    o_if_id_pc    = if_pc_q;
    o_if_id_instr = if_instr_q;
    o_pc          = pc_q;
    o_halt        = halt_q;
    o_state       = state_q;
  end
endmodule
